// File: rtl/phy_rx_lane_align_pkg.sv
// Shared types and constants for the serial PHY receive lane aligner.
package phy_rx_pkg;

    localparam int                BYTE_W        = 8;
    localparam logic [BYTE_W-1:0] COMMA_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } lane_state_e;

endpackage

// File: rtl/phy_rx_lane_align_if.sv
// Lane bundle between the pad-side serial inputs and the byte-domain unstriping logic.
interface phy_rx_lane_align_if #(
    parameter int LANES = 2
);
    logic [LANES-1:0]                     data_in;
    logic [LANES-1:0]                     lane_en;
    logic [phy_rx_pkg::BYTE_W*LANES-1:0]  data_out;
    logic [LANES-1:0]                     valid_out;
    logic [LANES-1:0]                     active_out;
    logic                                 all_active;

    modport master (
        output data_in, lane_en,
        input  data_out, valid_out, active_out, all_active
    );

    modport slave (
        input  data_in, lane_en,
        output data_out, valid_out, active_out, all_active
    );
endinterface

// File: rtl/phy_rx_lane_align_lane.sv
// One receive lane: input register chain, byte shift register and comma-lock FSM.
module phy_rx_lane
    import phy_rx_pkg::*;
#(
    parameter int                SYNC_STAGES = 1,
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEFAULT,
    parameter int                COMMA_COUNT = 4
) (
    input  logic              clk_8f,
    input  logic              reset,
    input  logic              data_in,
    input  logic              lane_en,
    output logic [BYTE_W-1:0] data_out,
    output logic              valid_out,
    output logic              active_out
);

    localparam int               CNT_W      = $clog2(COMMA_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(COMMA_COUNT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [BYTE_W-1:0]      sr_q;
    lane_state_e            state_q, state_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]       comma_cnt_q, comma_cnt_d;
    logic [BYTE_W-1:0]      data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   active_q;
    logic                   clear;
    logic                   is_comma;
    logic                   boundary;

    // NOTE: reset and lane disable are sampled on the clock edge, so they are plain terms of the clear condition, not sensitivity-list entries.
    assign clear    = !reset || !lane_en;
    assign is_comma = (sr_q == COMMA);
    assign boundary = (bit_cnt_q == 3'd7);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_8f) begin
        if (clear) begin
            sync_q <= '0;
            sr_q   <= '0;
        end else begin
            sync_q[0] <= data_in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            sr_q <= {sr_q[BYTE_W-2:0], sync_q[SYNC_STAGES-1]};
        end
    end

    always_ff @(posedge clk_8f) begin
        if (clear) begin
            state_q     <= HUNT;
            bit_cnt_q   <= '0;
            comma_cnt_q <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            comma_cnt_q <= comma_cnt_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            active_q    <= (state_d == ACTIVE);
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q + 3'd1;
        comma_cnt_d = comma_cnt_q;
        data_d      = data_q;
        valid_d     = 1'b0;

        unique case (state_q)
            HUNT: begin
                bit_cnt_d = '0;
                if (is_comma) begin
                    comma_cnt_d = CNT_W'(1);
                    state_d     = (COMMA_COUNT == 1) ? ACTIVE : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        comma_cnt_d = comma_cnt_q + CNT_W'(1);
                        if (comma_cnt_d == CNT_TARGET) begin
                            state_d = ACTIVE;
                        end
                    end else begin
                        comma_cnt_d = '0;
                        state_d     = HUNT;
                    end
                end
            end
            ACTIVE: begin
                // A data byte equal to the comma is treated as idle and dropped.
                if (boundary && !is_comma) begin
                    data_d  = sr_q;
                    valid_d = 1'b1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign active_out = active_q;

endmodule

// File: rtl/phy_rx_lane_align.sv
// Multi-lane receive front end: independent comma-aligned lanes plus an all-lanes-active flag.
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter int                LANES       = 2,
    parameter int                SYNC_STAGES = 1,
    parameter logic [BYTE_W-1:0] COMMA       = COMMA_DEFAULT,
    parameter int                COMMA_COUNT = 4
) (
    input  logic               clk_8f,
    input  logic               reset,
    phy_rx_lane_align_if.slave bus
);

    logic [BYTE_W-1:0] lane_data   [LANES];
    logic              lane_valid  [LANES];
    logic              lane_active [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_rx_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .COMMA       (COMMA),
            .COMMA_COUNT (COMMA_COUNT)
        ) u_lane (
            .clk_8f     (clk_8f),
            .reset      (reset),
            .data_in    (bus.data_in[i]),
            .lane_en    (bus.lane_en[i]),
            .data_out   (lane_data[i]),
            .valid_out  (lane_valid[i]),
            .active_out (lane_active[i])
        );
    end

    // Pack per-lane results onto the bus; lanes are not deskewed against each other.
    always_comb begin
        bus.data_out   = '0;
        bus.valid_out  = '0;
        bus.active_out = '0;
        bus.all_active = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            bus.data_out[BYTE_W*i +: BYTE_W] = lane_data[i];
            bus.valid_out[i]                 = lane_valid[i];
            bus.active_out[i]                = lane_active[i];
            bus.all_active                   = bus.all_active & lane_active[i];
        end
    end

endmodule
